// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;
    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, REFILL} state_t;

    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;
    localparam int BLOCK_W    = 256;
endpackage

// File: rtl/dcache_sram.sv
// Line storage: valid/dirty bits (reset), tag and data arrays (not reset).
// Combinational read by index; synchronous full-block or single-word write.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int IDX_W = 5,
    parameter int TAG_W = 22,
    parameter int BLK_W = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic                  rd_valid_o,
    output logic                  rd_dirty_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [BLK_W-1:0]      rd_data_o,
    input  logic                  blk_we_i,
    input  logic [TAG_W-1:0]      blk_tag_i,
    input  logic [BLK_W-1:0]      blk_data_i,
    input  logic                  word_we_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [31:0]           word_data_i,
    input  logic                  dirty_set_i,
    input  logic                  dirty_clr_i
);
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [BLK_W-1:0] data_mem [LINES];

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_mem[idx_i];
    assign rd_data_o  = data_mem[idx_i];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (blk_we_i) valid_d[idx_i] = 1'b1;
        if (dirty_set_i)      dirty_d[idx_i] = 1'b1;
        else if (dirty_clr_i) dirty_d[idx_i] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (blk_we_i) begin
            tag_mem[idx_i]  <= blk_tag_i;
            data_mem[idx_i] <= blk_data_i;
        end else if (word_we_i) begin
            data_mem[idx_i][{word_sel_i, 5'b00000} +: 32] <= word_data_i;
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache: zero-stall hits, stalls the
// pipeline through write-back, fill and refill on a miss.
module dcache_controller #(
    parameter int LINES   = 32,
    parameter int BLOCK_W = 256,
    parameter int TAG_W   = 32 - 5 - $clog2(LINES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cpu_req_i,
    input  logic               cpu_write_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [31:0]        cpu_data_i,
    output logic [31:0]        cpu_data_o,
    output logic               cpu_stall_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_addr_o,
    output logic [BLOCK_W-1:0] mem_data_o,
    input  logic [BLOCK_W-1:0] mem_data_i,
    input  logic               mem_ack_i
);
    import dcache_pkg::*;

    localparam int IDX_W = $clog2(LINES);

    state_t               state_q, state_d;
    logic                 mem_enable_q, mem_enable_d;
    logic                 mem_write_q, mem_write_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [BLOCK_W-1:0]   mem_data_q, mem_data_d;
    logic [BLOCK_W-1:0]   refill_q, refill_d;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      addr_tag;
    logic [WORD_SEL_W-1:0] word_sel;
    logic [1:0]            unused_byte_off;
    logic                  rd_valid, rd_dirty, hit;
    logic [TAG_W-1:0]      rd_tag;
    logic [BLOCK_W-1:0]    rd_data;
    logic [31:0]           rd_word, victim_addr, fill_addr;
    logic                  blk_we, word_we, dirty_set, dirty_clr;

    assign idx             = cpu_addr_i[OFFSET_W +: IDX_W];
    assign addr_tag        = cpu_addr_i[31 -: TAG_W];
    assign word_sel        = cpu_addr_i[OFFSET_W-1 -: WORD_SEL_W];
    assign unused_byte_off = cpu_addr_i[1:0];
    assign hit             = rd_valid && (rd_tag == addr_tag);
    assign rd_word         = rd_data[{word_sel, 5'b00000} +: 32];
    assign victim_addr     = {rd_tag, idx, {OFFSET_W{1'b0}}};
    assign fill_addr       = {cpu_addr_i[31:OFFSET_W], {OFFSET_W{1'b0}}};

    dcache_sram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .BLK_W (BLOCK_W)
    ) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (idx),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .blk_we_i    (blk_we),
        .blk_tag_i   (addr_tag),
        .blk_data_i  (refill_q),
        .word_we_i   (word_we),
        .word_sel_i  (word_sel),
        .word_data_i (cpu_data_i),
        .dirty_set_i (dirty_set),
        .dirty_clr_i (dirty_clr)
    );

    // Memory outputs are registered: they change only on the edge that enters
    // or leaves a memory state, so they hold steady through the ack cycle.
    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        refill_d     = refill_q;
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        blk_we       = 1'b0;
        word_we      = 1'b0;
        dirty_set    = 1'b0;
        dirty_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (cpu_write_i) begin
                            word_we   = 1'b1;
                            dirty_set = 1'b1;
                        end else begin
                            cpu_data_o = rd_word;
                        end
                    end else begin
                        cpu_stall_o  = 1'b1;
                        mem_enable_d = 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_d     = WRITEBACK;
                            mem_write_d = 1'b1;
                            mem_addr_d  = victim_addr;
                            mem_data_d  = rd_data;
                        end else begin
                            state_d     = FILL;
                            mem_write_d = 1'b0;
                            mem_addr_d  = fill_addr;
                            mem_data_d  = '0;
                        end
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                if (mem_enable_q && mem_ack_i) begin
                    state_d     = FILL;
                    mem_write_d = 1'b0;
                    mem_addr_d  = fill_addr;
                    mem_data_d  = '0;
                end
            end
            FILL: begin
                cpu_stall_o = 1'b1;
                if (mem_enable_q && mem_ack_i) begin
                    state_d      = REFILL;
                    refill_d     = mem_data_i;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = '0;
                    mem_data_d   = '0;
                end
            end
            REFILL: begin
                cpu_stall_o = 1'b1;
                blk_we      = 1'b1;
                dirty_clr   = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        refill_q <= refill_d;
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed vector table, reset/idle corner
// sequences, then random traffic against a flat-memory reference model.
module tb_dcache_controller;
    localparam int LINES = 32;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o, mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_ack_i;

    logic         resp_ack = 1'b0;
    logic [255:0] resp_data = '0;
    logic         inject_ack = 1'b0;
    assign mem_ack_i  = resp_ack | inject_ack;
    assign mem_data_i = resp_data;

    dcache_controller dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_write_i  (cpu_write_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ack_lat = 10;

    logic [255:0] bmem [logic [31:0]];
    logic [31:0]  wmem [logic [31:0]];
    logic [31:0]  wb_addr_q[$];
    logic [255:0] wb_data_q[$];
    logic [31:0]  fill_addr_q[$];

    bit          ref_valid [LINES];
    bit          ref_dirty [LINES];
    logic [31:0] ref_tag   [LINES];

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    function automatic logic [255:0] init_blk(input logic [31:0] ba);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[w*32 +: 32] = init_word(ba * 8 + w);
        return b;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = a >> 2;
        return wmem.exists(wa) ? wmem[wa] : init_word(wa);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: ack after ack_lat enabled cycles, checks request stability.
    int           cnt = 0;
    logic         snap_w, bad;
    logic [31:0]  snap_a;
    logic [255:0] snap_d;
    always @(negedge clk) begin
        resp_ack  = 1'b0;
        resp_data = '0;
        if (rst_i || !mem_enable_o) begin
            cnt = 0;
        end else begin
            cnt++;
            if (cnt == 1) begin
                snap_w = mem_write_o; snap_a = mem_addr_o; snap_d = mem_data_o; bad = 1'b0;
            end else if (mem_write_o !== snap_w || mem_addr_o !== snap_a || mem_data_o !== snap_d) begin
                bad = 1'b1;
            end
            if (cnt >= ack_lat) begin
                checks++;
                if (bad || mem_addr_o[4:0] != 5'd0) begin
                    failures++;
                    $display("FAIL mem_req_stable: addr %h changed=%0d required stable and block aligned", mem_addr_o, bad);
                end
                resp_ack = 1'b1;
                cnt = 0;
                if (mem_write_o) begin
                    bmem[mem_addr_o >> 5] = mem_data_o;
                    wb_addr_q.push_back(mem_addr_o);
                    wb_data_q.push_back(mem_data_o);
                end else begin
                    resp_data = bmem.exists(mem_addr_o >> 5) ? bmem[mem_addr_o >> 5] : init_blk(mem_addr_o >> 5);
                    fill_addr_q.push_back(mem_addr_o);
                end
            end
        end
    end

    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output int stalls, output logic [31:0] rd);
        int n;
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = a; cpu_data_i = d;
        #1;
        n = 0;
        while (cpu_stall_o && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles, required release", a, n);
        end
        stalls = n;
        rd = cpu_data_o;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cpu_req_i = 1'b0; cpu_write_i = 1'b0;
    endtask

    task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int idx, exp_st, st;
        logic [31:0] tg, rd;
        bit hit;
        idx = int'((a >> 5) % LINES);
        tg  = a >> 10;
        hit = ref_valid[idx] && ref_tag[idx] == tg;
        exp_st = hit ? 0 : 2 + ack_lat + ((ref_valid[idx] && ref_dirty[idx]) ? ack_lat : 0);
        do_access(wr, a, d, st, rd);
        chk($sformatf("model_stall@%h", a), st, exp_st);
        if (!wr) chk($sformatf("model_load@%h", a), rd, exp_word(a));
        else wmem[a >> 2] = d;
        ref_dirty[idx] = hit ? (ref_dirty[idx] | wr) : wr;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        logic [31:0] rdata;
        int          wbs;
        int          fills;
    } vec_t;
    vec_t vecs [7];

    initial begin
        logic [255:0] seed_blk, tmp;
        int           st;
        logic [31:0]  rd;

        seed_blk = init_blk(32'h2);
        seed_blk[31:0] = 32'h1234_5678;
        bmem[32'h2]  = seed_blk;
        wmem[32'h10] = 32'h1234_5678;

        vecs[0] = '{1'b0, 32'h0000_0040, 32'h0,         12, 32'h1234_5678,      0, 1};
        vecs[1] = '{1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0,  32'h0,              0, 0};
        vecs[2] = '{1'b0, 32'h0000_0044, 32'h0,         0,  32'hDEAD_BEEF,      0, 0};
        vecs[3] = '{1'b0, 32'h0000_0440, 32'h0,         22, init_word(32'h110), 1, 1};
        vecs[4] = '{1'b1, 32'h0000_0840, 32'hCAFE_F00D, 12, 32'h0,              0, 1};
        vecs[5] = '{1'b0, 32'h0000_0840, 32'h0,         0,  32'hCAFE_F00D,      0, 0};
        vecs[6] = '{1'b0, 32'h0000_0040, 32'h0,         22, 32'h1234_5678,      1, 1};

        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_data", cpu_data_o, 0);
        chk("rst_mem_en", mem_enable_o, 0);
        chk("rst_mem_wr", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data_lo", mem_data_o[31:0], 0);
        rst_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            int nwb, nfl, s;
            logic [31:0] r;
            nwb = wb_addr_q.size();
            nfl = fill_addr_q.size();
            do_access(vecs[i].wr, vecs[i].addr, vecs[i].data, s, r);
            chk($sformatf("vec%0d_stall", i), s, vecs[i].stall);
            if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), r, vecs[i].rdata);
            else wmem[vecs[i].addr >> 2] = vecs[i].data;
            chk($sformatf("vec%0d_wb", i), wb_addr_q.size() - nwb, vecs[i].wbs);
            chk($sformatf("vec%0d_fill", i), fill_addr_q.size() - nfl, vecs[i].fills);
        end
        chk("wb_count", wb_addr_q.size(), 2);
        chk("wb0_addr", wb_addr_q[0], 32'h40);
        tmp = wb_data_q[0];
        chk("wb0_word1", tmp[63:32], 32'hDEAD_BEEF);
        chk("wb1_addr", wb_addr_q[1], 32'h840);
        tmp = wb_data_q[1];
        chk("wb1_word0", tmp[31:0], 32'hCAFE_F00D);
        chk("fill_count", fill_addr_q.size(), 4);
        chk("fill1_addr", fill_addr_q[1], 32'h440);
        chk("fill2_addr", fill_addr_q[2], 32'h840);

        // Spurious acks while idle must not disturb anything.
        for (int i = 0; i < 20; i++) begin
            idle_cycle();
            inject_ack = 1'($urandom_range(0, 1));
            #1;
            chk("idle_stall", cpu_stall_o, 0);
            chk("idle_mem_en", mem_enable_o, 0);
        end
        inject_ack = 1'b0;
        do_access(1'b0, 32'h40, 32'h0, st, rd);
        chk("idle_hit_stall", st, 0);
        chk("idle_hit_data", rd, 32'h1234_5678);

        // Reset during FILL, with a late ack afterwards.
        @(negedge clk);
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h1000;
        repeat (3) @(negedge clk);
        #1;
        chk("midfill_en", mem_enable_o, 1);
        chk("midfill_wr", mem_write_o, 0);
        rst_i = 1'b1; cpu_req_i = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_en", mem_enable_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        inject_ack = 1'b1;
        @(negedge clk);
        inject_ack = 1'b0;
        #1;
        chk("late_ack_en", mem_enable_o, 0);
        chk("late_ack_stall", cpu_stall_o, 0);
        for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
        ack_lat = 10;
        do_access(1'b0, 32'h40, 32'h0, st, rd);
        chk("post_rst_miss_stall", st, 12);
        chk("post_rst_miss_data", rd, 32'h1234_5678);
        ref_valid[2] = 1'b1; ref_tag[2] = 32'h0; ref_dirty[2] = 1'b0;

        // Random traffic over 4 tags x 4 indices to force conflicts and evictions.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            ack_lat = $urandom_range(1, 6);
            model_access(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        idle_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
